// File: rtl/seq_alu_pkg.sv
// seq_alu shared types: opcodes, flag bit positions, FSM states.
// SEQ_ALU_DIV_EN selects whether DIV is an iterative op or illegal.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_CMP = 4'd7
  } op_e;

  localparam int NFLAGS = 6;
  localparam int FL_Z   = 0;
  localparam int FL_C   = 1;
  localparam int FL_N   = 2;
  localparam int FL_V   = 3;
  localparam int FL_DZ  = 4;
  localparam int FL_ILL = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Divider datapath exists only when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum;

`ifdef SEQ_ALU_DIV_EN
  logic           op_q, op_d;
  logic [WIDTH:0] shf;
  logic [WIDTH:0] sub;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    lo_d   = lo_q;
    hi_d   = hi_q;
    b_d    = b_q;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`ifdef SEQ_ALU_DIV_EN
    op_d = op_q;
    shf  = {hi_q, lo_q[WIDTH-1]};
    sub  = shf - {1'b0, b_q};
`endif
    if (start) begin
      cnt_d  = CW'(CYCLES);
      busy_d = 1'b1;
      lo_d   = a;
      hi_d   = '0;
      b_d    = b;
`ifdef SEQ_ALU_DIV_EN
      op_d = op;
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      // Borrow in sub[WIDTH] means the trial subtract failed: restore.
      if (op_q) begin
        hi_d = sub[WIDTH] ? shf[WIDTH-1:0] : sub[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ~sub[WIDTH]};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
      op_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      b_q    <= b_d;
`ifdef SEQ_ALU_DIV_EN
      op_q <= op_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: 1-cycle logic/arith ops, iterative MUL (and DIV when
// SEQ_ALU_DIV_EN is defined), valid/ready handshakes on both sides.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int MUL_DIV_CYCLES = WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic [WIDTH-1:0]  b_data,
  input  logic [WIDTH-1:0]  imm_data,
  input  logic              imm_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [WIDTH-1:0]  out_hi,
  output logic [NFLAGS-1:0] flags
);

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, b_sel;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [NFLAGS-1:0]  fl_q, fl_d;
  logic               accept, md_start, md_op;
  logic               md_busy, md_done;
  logic [WIDTH-1:0]   md_lo, md_hi;
  logic [WIDTH:0]     sum, dif;
  logic [WIDTH-1:0]   res;
  logic               ill;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = dat_q;
  assign out_hi    = hi_q;
  assign flags     = fl_q;
  assign b_sel     = imm_en ? imm_data : b_data;
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_iter(opr);
`ifdef SEQ_ALU_DIV_EN
  assign md_op = (opr == OP_DIV);
`else
  assign md_op = 1'b0;
`endif

  seq_alu_muldiv #(
    .WIDTH  (WIDTH),
    .CYCLES (MUL_DIV_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (md_op),
    .a     (a_data),
    .b     (b_sel),
    .busy  (md_busy),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    hi_d    = hi_q;
    fl_d    = fl_q;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    dif     = {1'b0, a_q} - {1'b0, b_q};
    res     = '0;
    ill     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = is_iter(opr) ? S_ITER : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_DONE;
        hi_d    = '0;
        fl_d    = '0;
        unique case (1'b1)
          (op_q == OP_ADD): begin
            res        = sum[WIDTH-1:0];
            fl_d[FL_C] = sum[WIDTH];
            fl_d[FL_V] = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (res[WIDTH-1] != a_q[WIDTH-1]);
          end
          (op_q == OP_SUB),
          (op_q == OP_CMP): begin
            res        = dif[WIDTH-1:0];
            fl_d[FL_C] = dif[WIDTH];
            fl_d[FL_V] = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (res[WIDTH-1] != a_q[WIDTH-1]);
          end
          (op_q == OP_AND): res = a_q & b_q;
          (op_q == OP_OR):  res = a_q | b_q;
          (op_q == OP_XOR): res = a_q ^ b_q;
          default:          ill = 1'b1;
        endcase
        if (ill) begin
          dat_d        = '0;
          fl_d         = '0;
          fl_d[FL_ILL] = 1'b1;
        end else begin
          dat_d      = (op_q == OP_CMP) ? a_q : res;
          fl_d[FL_N] = res[WIDTH-1];
          fl_d[FL_Z] = ~|res;
        end
      end
      S_ITER: begin
        if (md_done && !md_busy) begin
          state_d    = S_DONE;
          dat_d      = md_lo;
          hi_d       = md_hi;
          fl_d       = '0;
          fl_d[FL_N] = md_lo[WIDTH-1];
          fl_d[FL_Z] = ~|md_lo;
          if (op_q == OP_MUL)
            fl_d[FL_C] = |md_hi;
`ifdef SEQ_ALU_DIV_EN
          else
            fl_d[FL_DZ] = ~|b_q;
`endif
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dat_q   <= '0;
      hi_q    <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      hi_q    <= hi_d;
      fl_q    <= fl_d;
      if (accept) begin
        op_q <= opr;
        a_q  <= a_data;
        b_q  <= b_sel;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
// DIV vectors follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opr;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic [7:0] imm_data;
  logic       imm_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_hi;
  logic [5:0] flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic       ie;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [5:0] fl;
    int         lat;
  } vec_t;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opr       (opr),
    .a_data    (a_data),
    .b_data    (b_data),
    .imm_data  (imm_data),
    .imm_en    (imm_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hi    (out_hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op from a negedge; scramble inputs right after accept.
  task automatic run_op(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm,
    input  logic       ie,
    output int         lat,
    output logic [7:0] d,
    output logic [7:0] h,
    output logic [5:0] f
  );
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    opr      = op;
    a_data   = a;
    b_data   = b;
    imm_data = imm;
    imm_en   = ie;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opr      = 4'hE;
    a_data   = ~a;
    b_data   = ~b;
    imm_data = ~imm;
    imm_en   = ~ie;
    lat      = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    d = out_data;
    h = out_hi;
    f = flags;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_data, out_hi, flags} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 6'h00}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b d=%h h=%h f=%h",
               in_ready, out_valid, out_data, out_hi, flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_release got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_alu();
    vec_t v[9];
    int lat;
    logic [7:0] d, h;
    logic [5:0] f;
    v[0] = '{4'd0, 8'hF0, 8'h20, 8'h00, 1'b0, 8'h10, 8'h00, 6'h02, 1};
    v[1] = '{4'd0, 8'h7F, 8'h01, 8'h00, 1'b0, 8'h80, 8'h00, 6'h0C, 1};
    v[2] = '{4'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 6'h03, 1};
    v[3] = '{4'd1, 8'h05, 8'h09, 8'h03, 1'b1, 8'h02, 8'h00, 6'h00, 1};
    v[4] = '{4'd1, 8'h80, 8'h01, 8'h00, 1'b0, 8'h7F, 8'h00, 6'h08, 1};
    v[5] = '{4'd7, 8'h03, 8'h05, 8'h00, 1'b0, 8'h03, 8'h00, 6'h06, 1};
    v[6] = '{4'd4, 8'hF0, 8'h3C, 8'h00, 1'b0, 8'h30, 8'h00, 6'h00, 1};
    v[7] = '{4'd5, 8'h0F, 8'hF0, 8'h00, 1'b0, 8'hFF, 8'h00, 6'h04, 1};
    v[8] = '{4'd6, 8'h55, 8'h55, 8'h00, 1'b0, 8'h00, 8'h00, 6'h01, 1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].ie, lat, d, h, f);
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL alu[%0d] latency got %0d want %0d", i, lat, v[i].lat);
      end
      total++;
      if ({d, h, f} !== {v[i].lo, v[i].hi, v[i].fl}) begin
        bad++;
        $display("FAIL alu[%0d] result got %h/%h/%h want %h/%h/%h",
                 i, d, h, f, v[i].lo, v[i].hi, v[i].fl);
      end
      retire();
    end
  endtask

  task automatic test_mul();
    vec_t v[3];
    int lat;
    logic [7:0] d, h;
    logic [5:0] f;
    v[0] = '{4'd2, 8'h12, 8'h34, 8'h00, 1'b0, 8'hA8, 8'h03, 6'h06, 9};
    v[1] = '{4'd2, 8'hFF, 8'h00, 8'hFF, 1'b1, 8'h01, 8'hFE, 6'h02, 9};
    v[2] = '{4'd2, 8'h00, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00, 6'h01, 9};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].ie, lat, d, h, f);
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL mul[%0d] latency got %0d want %0d", i, lat, v[i].lat);
      end
      total++;
      if ({d, h, f} !== {v[i].lo, v[i].hi, v[i].fl}) begin
        bad++;
        $display("FAIL mul[%0d] result got %h/%h/%h want %h/%h/%h",
                 i, d, h, f, v[i].lo, v[i].hi, v[i].fl);
      end
      retire();
    end
  endtask

  task automatic test_div_illegal();
    vec_t v[4];
    int lat;
    logic [7:0] d, h;
    logic [5:0] f;
`ifdef SEQ_ALU_DIV_EN
    v[0] = '{4'd3, 8'd100, 8'd7, 8'h00, 1'b0, 8'h0E, 8'h02, 6'h00, 9};
    v[1] = '{4'd3, 8'h55, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h55, 6'h14, 9};
`else
    v[0] = '{4'd3, 8'd100, 8'd7, 8'h00, 1'b0, 8'h00, 8'h00, 6'h20, 1};
    v[1] = '{4'd3, 8'h55, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 6'h20, 1};
`endif
    v[2] = '{4'd9, 8'h12, 8'h34, 8'h00, 1'b0, 8'h00, 8'h00, 6'h20, 1};
    v[3] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 6'h20, 1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].ie, lat, d, h, f);
      total++;
      if (lat !== v[i].lat) begin
        bad++;
        $display("FAIL divill[%0d] latency got %0d want %0d",
                 i, lat, v[i].lat);
      end
      total++;
      if ({d, h, f} !== {v[i].lo, v[i].hi, v[i].fl}) begin
        bad++;
        $display("FAIL divill[%0d] result got %h/%h/%h want %h/%h/%h",
                 i, d, h, f, v[i].lo, v[i].hi, v[i].fl);
      end
      retire();
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [7:0] d, h;
    logic [5:0] f;
    run_op(4'd2, 8'h12, 8'h34, 8'h00, 1'b0, lat, d, h, f);
    total++;
    if ({lat == 9, d, h, f} !== {1'b1, 8'hA8, 8'h03, 6'h06}) begin
      bad++;
      $display("FAIL hold_setup got lat=%0d %h/%h/%h", lat, d, h, f);
    end
    for (int k = 0; k < 5; k++) begin
      opr      = 4'd0;
      a_data   = 8'(k);
      b_data   = 8'h01;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_data, out_hi, flags} !==
          {1'b1, 1'b0, 8'hA8, 8'h03, 6'h06}) begin
        bad++;
        $display("FAIL hold[%0d] got v=%b r=%b %h/%h/%h", k,
                 out_valid, in_ready, out_data, out_hi, flags);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL hold_release got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] d, h;
    logic [5:0] f;
    run_op(4'd0, 8'h01, 8'h02, 8'h00, 1'b0, lat, d, h, f);
    total++;
    if ({lat == 1, d, h, f} !== {1'b1, 8'h03, 8'h00, 6'h00}) begin
      bad++;
      $display("FAIL b2b_add got lat=%0d %h/%h/%h want 1 03/00/00",
               lat, d, h, f);
    end
    retire();
    run_op(4'd6, 8'hA5, 8'h0F, 8'h00, 1'b0, lat, d, h, f);
    total++;
    if ({lat == 1, d, h, f} !== {1'b1, 8'hAA, 8'h00, 6'h04}) begin
      bad++;
      $display("FAIL b2b_xor got lat=%0d %h/%h/%h want 1 aa/00/04",
               lat, d, h, f);
    end
    retire();
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    logic [7:0] d, h;
    logic [5:0] f;
    opr      = 4'd2;
    a_data   = 8'h12;
    b_data   = 8'h34;
    imm_en   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_hi, flags} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 6'h00}) begin
      bad++;
      $display("FAIL midreset_async got r=%b v=%b %h/%h/%h",
               in_ready, out_valid, out_data, out_hi, flags);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if ({seen, in_ready} !== {32'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_stale got valid_cycles=%0d rdy=%b want 0 1",
               seen, in_ready);
    end
    run_op(4'd0, 8'h0F, 8'h01, 8'h00, 1'b0, lat, d, h, f);
    total++;
    if ({lat == 1, d, h, f} !== {1'b1, 8'h10, 8'h00, 6'h00}) begin
      bad++;
      $display("FAIL midreset_after got lat=%0d %h/%h/%h want 1 10/00/00",
               lat, d, h, f);
    end
    retire();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opr       = '0;
    a_data    = '0;
    b_data    = '0;
    imm_data  = '0;
    imm_en    = 1'b0;
    test_reset();
    test_alu();
    test_mul();
    test_div_illegal();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
